// File: rtl/dadda_seq_pkg.sv
// Shared definitions for the Dadda multiplier stream sequencer:
// operand/product widths, FSM state encoding and word-count helpers.
package dadda_seq_pkg;

    localparam int OP_W   = 64;
    localparam int PROD_W = 129;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    // Number of stream words needed to carry both 64-bit operands.
    function automatic int in_words(input int word_w);
        return (2 * OP_W) / word_w;
    endfunction

    // Number of stream words needed to carry the 129-bit product (rounded up).
    function automatic int out_words(input int word_w);
        return (PROD_W + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/dadda_seq_serializer.sv
// Product serializer: captures the 129-bit multiplier result and streams it
// out least-significant word first, zero-padding above bit 128 in the last
// word. Holds its word under backpressure.
module dadda_seq_serializer
    import dadda_seq_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap,
    input  logic              cap_zero,
    input  logic [PROD_W-1:0] mul_c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              done
);

    localparam int         OUT_WORDS = out_words(WORD_W);
    localparam int         PAD_W     = OUT_WORDS * WORD_W - PROD_W;
    localparam logic [3:0] LAST_J    = 4'(OUT_WORDS - 1);

    logic [PROD_W-1:0]           prod_q;
    logic [3:0]                  j_q;
    logic                        vld_q;
    logic [OUT_WORDS*WORD_W-1:0] prod_pad;
    logic [7:0]                  rd_lsb;
    logic                        hs;
    logic                        at_last;

    assign prod_pad = {{PAD_W{1'b0}}, prod_q};
    assign rd_lsb   = 8'(j_q) * 8'(WORD_W);
    assign hs       = vld_q & out_ready;
    assign at_last  = (j_q == LAST_J);
    assign done     = hs & at_last;

    // Capture the product, then advance one word per accepted handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_q <= '0;
            j_q    <= '0;
            vld_q  <= 1'b0;
        end else if (cap) begin
            prod_q <= cap_zero ? '0 : mul_c;
            j_q    <= '0;
            vld_q  <= 1'b1;
        end else if (hs) begin
            if (at_last) begin
                vld_q <= 1'b0;
                j_q   <= '0;
            end else begin
                j_q <= j_q + 4'd1;
            end
        end
    end

    // Word mux is gated by valid so the bus reads zero while idle.
    always_comb begin
        out_valid = vld_q;
        out_data  = '0;
        out_last  = 1'b0;
        if (vld_q) begin
            out_data = prod_pad[rd_lsb +: WORD_W];
            out_last = at_last;
        end
    end

endmodule

// File: rtl/dadda_mul_stream_sequencer.sv
// Streaming front/back end for an external 64x64 combinational Dadda
// multiplier. Operand words (A low-to-high, then B low-to-high) are
// assembled into registers that drive the core, the core is given MUL_WAIT
// cycles to settle, and the 129-bit product is streamed out as words.
// Optional build macro DADDA_SEQ_ZERO_BYPASS_EN: when either operand is zero
// the settle interval is skipped and a zero product is emitted directly.
module dadda_mul_stream_sequencer
    import dadda_seq_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int MUL_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic [PROD_W-1:0] mul_c,
    output logic              busy
);

    localparam int         IN_WORDS  = in_words(WORD_W);
    localparam logic [3:0] LAST_K    = 4'(IN_WORDS - 1);
    localparam logic [3:0] WAIT_INIT = 4'(MUL_WAIT - 1);

    seq_state_t          state_q;
    seq_state_t          state_d;
    logic [3:0]          k_q;
    logic [3:0]          wait_q;
    logic [2*OP_W-1:0]   ops_q;
    logic [2*OP_W-1:0]   ops_d;
    logic [7:0]          wr_lsb;
    logic                beat;
    logic                last_beat;
    logic                cap;
    logic                cap_zero;
    logic                ser_done;
    logic                zero_op;

    // Handshake is derived from the state register directly so it does not
    // loop back through the FSM output logic.
    assign beat      = in_valid & (state_q == LOAD);
    assign last_beat = beat & (k_q == LAST_K);
    assign wr_lsb    = 8'(k_q) * 8'(WORD_W);

    assign mul_a = ops_q[OP_W-1:0];
    assign mul_b = ops_q[2*OP_W-1:OP_W];

    // Operand image as it will look after the current beat is written.
    always_comb begin
        ops_d = ops_q;
        ops_d[wr_lsb +: WORD_W] = in_data;
    end

`ifdef DADDA_SEQ_ZERO_BYPASS_EN
    // Zero test uses the post-write image so the final B word is included.
    assign zero_op = (ops_d[OP_W-1:0] == '0) || (ops_d[2*OP_W-1:OP_W] == '0);
`else
    assign zero_op = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and control outputs.
    always_comb begin
        state_d  = state_q;
        cap      = 1'b0;
        cap_zero = 1'b0;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (last_beat) begin
                    if (zero_op) begin
                        cap      = 1'b1;
                        cap_zero = 1'b1;
                        state_d  = DRAIN;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (wait_q == 4'd0) begin
                    cap     = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (ser_done) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Operand deserializer and settle counter; operands only change on beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ops_q  <= '0;
            k_q    <= '0;
            wait_q <= '0;
        end else if (beat) begin
            ops_q <= ops_d;
            if (last_beat) begin
                k_q    <= '0;
                wait_q <= WAIT_INIT;
            end else begin
                k_q <= k_q + 4'd1;
            end
        end else if ((state_q == WAIT) && (wait_q != 4'd0)) begin
            wait_q <= wait_q - 4'd1;
        end
    end

    dadda_seq_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap       (cap),
        .cap_zero  (cap_zero),
        .mul_c     (mul_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (ser_done)
    );

endmodule

// File: tb/tb_dadda_mul_stream_sequencer.sv
// Directed bench for dadda_mul_stream_sequencer (WORD_W=32). A behavioural
// multiplier stands in for the external core; a second instance with
// MUL_WAIT=4 covers the zero-operand latency case.
module tb_dadda_mul_stream_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic [63:0]  mul_a;
    logic [63:0]  mul_b;
    logic [128:0] mul_c;
    logic         busy;

    logic         in_valid4;
    logic         in_ready4;
    logic [31:0]  in_data4;
    logic         out_valid4;
    logic         out_ready4;
    logic [31:0]  out_data4;
    logic         out_last4;
    logic [63:0]  mul_a4;
    logic [63:0]  mul_b4;
    logic [128:0] mul_c4;
    logic         busy4;

    logic         force_en;
    logic [128:0] force_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mul_c  = force_en ? force_c : ({65'd0, mul_a} * {65'd0, mul_b});
    assign mul_c4 = {65'd0, mul_a4} * {65'd0, mul_b4};

    dadda_mul_stream_sequencer #(.WORD_W(32), .MUL_WAIT(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .busy(busy)
    );

    dadda_mul_stream_sequencer #(.WORD_W(32), .MUL_WAIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .out_last(out_last4), .mul_a(mul_a4), .mul_b(mul_b4), .mul_c(mul_c4),
        .busy(busy4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_op(input logic [63:0] a, input logic [63:0] b, input int gap);
        logic [127:0] ops;
        ops = {b, a};
        for (int w = 0; w < 4; w++) begin
            repeat (gap) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = ops[w*32 +: 32];
            chk($sformatf("in_ready_load[%0d]", w), in_ready, 1'b1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input logic [159:0] exp, input logic [63:0] ea, input logic [63:0] eb,
                         input int lat, input int stall_at, input int stall_n);
        int n;
        n = 1;
        out_ready = 1'b1;
        while (!out_valid && n <= 20) begin
            chk("in_ready_wait", in_ready, 1'b0);
            chk("mul_a_wait", mul_a, ea);
            chk("mul_b_wait", mul_b, eb);
            tick();
            n++;
        end
        chk("latency", n, lat);
        for (int w = 0; w < 5; w++) begin
            if (w == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    chk("stall_valid", out_valid, 1'b1);
                    chk("stall_data", out_data, exp[w*32 +: 32]);
                    chk("stall_last", out_last, (w == 4));
                    chk("stall_in_ready", in_ready, 1'b0);
                    tick();
                end
                out_ready = 1'b1;
            end
            chk($sformatf("out_valid[%0d]", w), out_valid, 1'b1);
            chk($sformatf("out_data[%0d]", w), out_data, exp[w*32 +: 32]);
            chk($sformatf("out_last[%0d]", w), out_last, (w == 4));
            chk($sformatf("in_ready_drain[%0d]", w), in_ready, 1'b0);
            chk($sformatf("busy_drain[%0d]", w), busy, 1'b1);
            chk("mul_a_drain", mul_a, ea);
            chk("mul_b_drain", mul_b, eb);
            tick();
        end
        in_valid = 1'b0;
        chk("out_valid_after", out_valid, 1'b0);
        chk("in_ready_after", in_ready, 1'b1);
        chk("busy_after", busy, 1'b0);
        chk("out_last_after", out_last, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [63:0] ops4 [4];

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        in_valid4  = 1'b0;
        in_data4   = '0;
        out_ready4 = 1'b1;
        force_en   = 1'b0;
        force_c    = '0;
        tick();
        tick();

        // Reset state
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mul_a", mul_a, 64'h0);
        chk("rst_mul_b", mul_b, 64'h0);
        rst_n = 1'b1;
        tick();

        // 1: 3 * 5, back-to-back
        send_op(64'd3, 64'd5, 0);
        drain(160'hF, 64'd3, 64'd5, 3, -1, 0);

        // 2: all-ones squared
        send_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        drain({32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 32'h1},
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3, -1, 0);

        // 3: backpressure on word 2
        send_op(64'd3, 64'd5, 0);
        drain(160'hF, 64'd3, 64'd5, 3, 2, 3);

        // 4: bubbles on input, in_valid held high through WAIT/DRAIN
        send_op(64'h0000_0001_0000_0003, 64'd5, 2);
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        drain({32'h0, 32'h0, 32'h0, 32'h5, 32'hF}, 64'h0000_0001_0000_0003, 64'd5, 3, -1, 0);
        send_op(64'd2, 64'd9, 0);
        drain(160'h12, 64'd2, 64'd9, 3, -1, 0);

        // 5: reset during the third output word
        send_op(64'd3, 64'd5, 0);
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk("pre_rst_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_mul_a", mul_a, 64'h0);
        chk("midrst_mul_b", mul_b, 64'h0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_out_data", out_data, 32'h0);
        rst_n = 1'b1;
        tick();
        send_op(64'd7, 64'd6, 0);
        drain(160'h2A, 64'd7, 64'd6, 3, -1, 0);

        // 7: product bit 128 carried to the final word
        force_en = 1'b1;
        force_c  = 129'h1_00000001_00000002_00000003_00000004;
        send_op(64'd1, 64'd1, 0);
        drain({32'h1, 32'h1, 32'h2, 32'h3, 32'h4}, 64'd1, 64'd1, 3, 2, 2);
        force_en = 1'b0;

        // 6: zero operand on the MUL_WAIT=4 instance
        ops4[0] = 64'h0;
        ops4[1] = 64'h0;
        ops4[2] = 64'h1234;
        ops4[3] = 64'h0;
        for (int w = 0; w < 4; w++) begin
            in_valid4 = 1'b1;
            in_data4  = ops4[w][31:0];
            chk("in_ready4", in_ready4, 1'b1);
            tick();
        end
        in_valid4 = 1'b0;
        n = 1;
        while (!out_valid4 && n <= 20) begin
            tick();
            n++;
        end
`ifdef DADDA_SEQ_ZERO_BYPASS_EN
        chk("zero_latency", n, 1);
`else
        chk("zero_latency", n, 5);
`endif
        chk("zero_mul_a4", mul_a4, 64'h0);
        chk("zero_mul_b4", mul_b4, 64'h1234);
        for (int w = 0; w < 5; w++) begin
            chk($sformatf("zero_valid[%0d]", w), out_valid4, 1'b1);
            chk($sformatf("zero_data[%0d]", w), out_data4, 32'h0);
            chk($sformatf("zero_last[%0d]", w), out_last4, (w == 4));
            tick();
        end
        chk("zero_valid_after", out_valid4, 1'b0);
        chk("zero_in_ready_after", in_ready4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
